// File: rtl/lfsr_uart_tx.sv
// lfsr_uart_tx: byte-serial UART transmitter fed by the LFSR stage.
//
// Frame: start bit (0), 8 data bits LSB first, optional even-parity bit, one stop bit (1).
// Each bit is held for CLKS_PER_BIT clock cycles. Input side uses a valid/ready handshake;
// a byte is accepted on a rising edge with in_valid && in_ready and its start bit is driven
// from that same edge.
//
// Build option:
//   UART_PARITY_EN - when defined, an even-parity bit is inserted between data bit 7 and
//                    the stop bit (11-bit frame). When undefined, the frame is 10 bits.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   ena       in   enable; gates only acceptance of new bytes
//   in_valid  in   upstream byte available
//   in_data   in   byte to transmit, sampled on the accepting edge
//   in_ready  out  block can accept a byte this cycle (idle && ena)
//   tx        out  serial line, idle high, driven straight from a flop
//   busy      out  frame in progress, registered with the state

module lfsr_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  localparam logic [15:0] BitLast = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e      r_state;
  logic        r_tx;
  logic        r_busy;
  logic [15:0] r_timer;
  logic [2:0]  r_idx;
  logic [7:0]  r_shreg;

  logic        w_bit_done;
  logic [2:0]  w_idx_next;

  assign w_bit_done = (r_timer == 16'd0);
  assign w_idx_next = r_idx + 3'd1;

  assign in_ready = (r_state == StIdle) && ena;
  assign tx       = r_tx;
  assign busy     = r_busy;

  // The latched byte is kept intact for the whole frame and indexed by r_idx, so the
  // parity bit can be taken from it directly at the end of the data phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_timer <= 16'd0;
      r_idx   <= 3'd0;
      r_shreg <= 8'h00;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid && in_ready) begin
            r_shreg <= in_data;
            r_state <= StStart;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_timer <= BitLast;
          end
        end

        StStart: begin
          if (!w_bit_done) begin
            r_timer <= r_timer - 16'd1;
          end else begin
            r_state <= StData;
            r_tx    <= r_shreg[0];
            r_idx   <= 3'd0;
            r_timer <= BitLast;
          end
        end

        StData: begin
          if (!w_bit_done) begin
            r_timer <= r_timer - 16'd1;
          end else begin
            r_timer <= BitLast;
            if (r_idx == 3'd7) begin
              r_idx <= 3'd0;
`ifdef UART_PARITY_EN
              r_state <= StParity;
              r_tx    <= ^r_shreg;
`else
              r_state <= StStop;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_idx <= w_idx_next;
              r_tx  <= r_shreg[w_idx_next];
            end
          end
        end

`ifdef UART_PARITY_EN
        StParity: begin
          if (!w_bit_done) begin
            r_timer <= r_timer - 16'd1;
          end else begin
            r_state <= StStop;
            r_tx    <= 1'b1;
            r_timer <= BitLast;
          end
        end
`endif

        StStop: begin
          if (!w_bit_done) begin
            r_timer <= r_timer - 16'd1;
          end else begin
            // Return to idle for one cycle; in_ready is visible there before the next accept.
            r_state <= StIdle;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= StIdle;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_timer <= 16'd0;
          r_idx   <= 3'd0;
        end
      endcase
    end
  end

endmodule
